glb_psum_gather: RTL and testbench

Output-side gather stage for the global PE set. It collects partial-sum words from the NUM_COL PE output ports and serialises them through a round-robin arbiter into one tagged stream for the global buffer write path, using a FIFO. Frame boundaries are tracked per column, so words from the next tile never interleave with the current one.

---
 rtl/glb_psum_gather.sv | 175 +++++++++++++++++
 tb/tb_glb_psum_gather.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_psum_gather.sv
// Gathers partial sums from NUM_COL PE columns via round-robin into one tagged FWFT stream (GLB_PSUM_GATHER_CNT_EN adds frame_words).
// Latency: a word accepted at edge N is on out_* in cycle N+1; sustains 1 word/cycle.
// Backpressure: col_ready is zero while the FIFO is full, flush is high or reset is asserted.

module glb_psum_gather_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign pop_vld = (count != '0);
  assign push    = push_vld && (count != FULL);
  assign pop     = pop_rdy && pop_vld;
  // Head is forced to zero when empty so the output reads as zero out of reset.
  assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_dat;
  end
endmodule

module glb_psum_gather #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_COL-1:0]            col_valid,
  output logic [NUM_COL-1:0]            col_ready,
  input  logic [NUM_COL*DATA_WIDTH-1:0] col_data,
  input  logic [NUM_COL-1:0]            col_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_COL)-1:0]    out_col,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
`ifdef GLB_PSUM_GATHER_CNT_EN
  ,
  output logic [15:0]                   frame_words
`endif
);
  localparam int CW = $clog2(NUM_COL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CW + 1 + DATA_WIDTH;
  localparam logic [CW:0]   NC       = (CW+1)'(NUM_COL);
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COL - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  logic [CW-1:0]         ptr;
  logic [NUM_COL-1:0]    done_mask;
  logic [NUM_COL-1:0]    eligible;
  logic [NUM_COL-1:0]    gnt_oh;
  logic [CW-1:0]         gnt_idx;
  logic                  gnt_vld;
  logic [CW:0]           cand;
  logic                  accept;
  logic                  acc_last;
  logic                  last_frame;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [EW-1:0]         push_dat;
  logic [EW-1:0]         head_dat;
  logic                  fifo_pop;

  assign eligible = col_valid & ~done_mask;

  // First eligible column at or after ptr, wrapping modulo NUM_COL.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_COL; k++) begin
      cand = {1'b0, ptr} + (CW+1)'(k);
      if (cand >= NC) cand = cand - NC;
      if (!gnt_vld && eligible[cand[CW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[CW-1:0];
      end
    end
  end

  assign gnt_oh    = gnt_vld ? ({{(NUM_COL-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign col_ready = (gnt_vld && !flush && !rst && (fifo_count != FULL)) ? gnt_oh : '0;
  assign accept    = |(col_valid & col_ready);
  assign acc_data  = col_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign acc_last  = col_last[gnt_idx];
  // The granted column is never done, so OR-ing it in tests "all others done".
  assign last_frame = acc_last && (&(done_mask | gnt_oh));
  assign push_dat   = {gnt_idx, last_frame, acc_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      done_mask <= '0;
    end else if (flush) begin
      ptr       <= '0;
      done_mask <= '0;
    end else if (accept) begin
      ptr <= (gnt_idx == LAST_COL) ? '0 : gnt_idx + CW'(1);
      if (acc_last) done_mask <= last_frame ? '0 : (done_mask | gnt_oh);
    end
  end

  glb_psum_gather_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push_vld (accept),
    .push_dat (push_dat),
    .pop_rdy  (out_ready),
    .pop_vld  (out_valid),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

  assign {out_col, out_last, out_data} = head_dat;
  assign fifo_pop = out_valid && out_ready;
  assign busy     = (fifo_count != '0) || (|done_mask);

`ifdef GLB_PSUM_GATHER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_words <= '0;
    end else if (flush) begin
      frame_words <= '0;
    end else if (fifo_pop) begin
      if (out_last)                      frame_words <= '0;
      else if (frame_words != 16'hFFFF)  frame_words <= frame_words + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_glb_psum_gather.sv
// Directed bench for glb_psum_gather: vector table plus multi-cycle sequences (frames, full FIFO, flush, reset).
module tb_glb_psum_gather;
  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [7:0]   col_valid;
  logic [7:0]   col_ready;
  logic [127:0] col_data;
  logic [7:0]   col_last;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [2:0]   out_col;
  logic         out_last;
  logic [4:0]   fifo_count;
  logic         busy;
`ifdef GLB_PSUM_GATHER_CNT_EN
  logic [15:0]  frame_words;
`endif

  int checks = 0;
  int errors = 0;

  glb_psum_gather #(.DATA_WIDTH(16), .NUM_COL(8), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_data   (col_data),
    .col_last   (col_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_last   (out_last),
    .fifo_count (fifo_count),
    .busy       (busy)
`ifdef GLB_PSUM_GATHER_CNT_EN
    ,
    .frame_words(frame_words)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v;
    logic [7:0]  l;
    logic        ordy;
    logic [15:0] base;
    logic [7:0]  e_rdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [2:0]  e_oc;
    logic        e_ol;
    logic [4:0]  e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t tbl [12];
  int   fm_col [8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Column i carries base+i.
  task automatic drive(input logic [7:0] v, input logic [7:0] l, input logic ordy, input logic [15:0] base);
    col_valid = v;
    col_last  = l;
    out_ready = ordy;
    for (int i = 0; i < 8; i++) col_data[i*16 +: 16] = base + 16'(i);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    drive(8'hFF, 8'h00, 1'b0, 16'h0000);
    flush = 1'b1;
    #4;
    chk("flush_rdy", col_ready, 8'h00);
    nxt();
    flush = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 16'h0000);
    #4;
    chk("flush_clr", {fifo_count, out_valid, busy}, {5'd0, 1'b0, 1'b0});
    nxt();
  endtask

  // Leaves fifo_count=5 and done_mask=8'h0F, returning mid-cycle.
  task automatic build5();
    for (int k = 0; k < 4; k++) begin
      drive(8'h0F, 8'h0F, 1'b0, 16'hB000);
      nxt();
    end
    drive(8'h10, 8'h00, 1'b0, 16'hB000);
    nxt();
    drive(8'h00, 8'h00, 1'b0, 16'h0000);
    #4;
    chk("build5", {fifo_count, busy}, {5'd5, 1'b1});
  endtask

  initial begin
    tbl[0]  = '{8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, 5'd0, 1'b0};
    tbl[1]  = '{8'h04, 8'h00, 1'b1, 16'h1232, 8'h04, 1'b0, 16'h0000, 3'd0, 1'b0, 5'd0, 1'b0};
    tbl[2]  = '{8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b1, 16'h1234, 3'd2, 1'b0, 5'd1, 1'b1};
    tbl[3]  = '{8'hFF, 8'h00, 1'b1, 16'h0100, 8'h08, 1'b0, 16'h0000, 3'd0, 1'b0, 5'd0, 1'b0};
    tbl[4]  = '{8'hFF, 8'h00, 1'b1, 16'h0200, 8'h10, 1'b1, 16'h0103, 3'd3, 1'b0, 5'd1, 1'b1};
    tbl[5]  = '{8'hFF, 8'h00, 1'b1, 16'h0300, 8'h20, 1'b1, 16'h0204, 3'd4, 1'b0, 5'd1, 1'b1};
    tbl[6]  = '{8'hFF, 8'h40, 1'b1, 16'h0400, 8'h40, 1'b1, 16'h0305, 3'd5, 1'b0, 5'd1, 1'b1};
    tbl[7]  = '{8'hFF, 8'h00, 1'b1, 16'h0500, 8'h80, 1'b1, 16'h0406, 3'd6, 1'b0, 5'd1, 1'b1};
    tbl[8]  = '{8'hFF, 8'h00, 1'b0, 16'h0600, 8'h01, 1'b1, 16'h0507, 3'd7, 1'b0, 5'd1, 1'b1};
    tbl[9]  = '{8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b1, 16'h0507, 3'd7, 1'b0, 5'd2, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b1, 16'h0600, 3'd0, 1'b0, 5'd1, 1'b1};
    tbl[11] = '{8'h00, 8'h00, 1'b1, 16'h0000, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, 5'd0, 1'b1};
    fm_col = '{3, 4, 5, 6, 7, 0, 1, 2};

    rst   = 1'b1;
    flush = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 16'h0000);
    #2;
    chk("reset", {col_ready, out_valid, out_data, out_col, out_last, fifo_count, busy}, 35'd0);
    #10;
    rst = 1'b0;
    nxt();

    // Vector table: check state at mid-cycle, then clock.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].ordy, tbl[i].base);
      #4;
      chk($sformatf("vec%0d", i),
          {col_ready, out_valid, out_data, out_col, out_last, fifo_count, busy},
          {tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_oc, tbl[i].e_ol, tbl[i].e_cnt, tbl[i].e_busy});
      nxt();
    end
    do_flush();

    // Round robin from ptr=0, one word per cycle.
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      oh = 8'b1 << (k % 8);
      drive(8'hFF, 8'h00, 1'b1, 16'h0700);
      #4;
      chk("rr_rdy", col_ready, oh);
      if (k > 0) chk("rr_out", {out_valid, out_col, fifo_count}, {1'b1, 3'((k-1) % 8), 5'd1});
      nxt();
    end
    drive(8'h00, 8'h00, 1'b1, 16'h0000);
    nxt();
    do_flush();

    // Frame masking: column 3 finishes first and is skipped until the frame completes.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] oh;
      oh = 8'b1 << fm_col[k];
      drive((k == 0) ? 8'h08 : 8'hFF, 8'hFF, 1'b1, 16'h0800);
      #4;
      chk("fm_rdy", col_ready, oh);
      if (k > 0) chk("fm_out", {out_valid, out_col, out_last}, {1'b1, 3'(fm_col[k-1]), 1'b0});
      nxt();
    end
    drive(8'h00, 8'h00, 1'b1, 16'h0000);
    #4;
    chk("fm_end", {out_valid, out_col, out_last, out_data, busy}, {1'b1, 3'd2, 1'b1, 16'h0802, 1'b1});
    nxt();
    drive(8'h08, 8'h00, 1'b0, 16'h0000);
    #4;
    chk("fm_clear", {busy, col_ready}, {1'b0, 8'h08});
    nxt();
    do_flush();

    // Full FIFO.
    for (int k = 0; k < 16; k++) begin
      drive(8'hFF, 8'h00, 1'b0, 16'hA000);
      #4;
      chk("full_acc", 64'($onehot(col_ready)), 64'd1);
      nxt();
    end
    drive(8'hFF, 8'h00, 1'b0, 16'hA000);
    #4;
    chk("full_stop", {col_ready, fifo_count, out_col, out_data}, {8'h00, 5'd16, 3'd0, 16'hA000});
    nxt();
    drive(8'hFF, 8'h00, 1'b1, 16'hA000);
    #4;
    chk("full_pop", {col_ready, out_valid}, {8'h00, 1'b1});
    nxt();
    drive(8'hFF, 8'h00, 1'b0, 16'hA000);
    #4;
    chk("full_refill", {fifo_count, col_ready, out_col}, {5'd15, 8'h01, 3'd1});
    nxt();
    #4;
    chk("full_again", {fifo_count, col_ready}, {5'd16, 8'h00});
    nxt();
    do_flush();

    // Mid-frame flush, then mid-frame asynchronous reset.
    build5();
    nxt();
    do_flush();
    build5();
    nxt();
    drive(8'hFF, 8'h00, 1'b0, 16'h0000);
    rst = 1'b1;
    #1;
    chk("rst_clr", {fifo_count, out_valid, busy, col_ready, out_data}, {5'd0, 1'b0, 1'b0, 8'h00, 16'h0000});
    #3;
    rst = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 16'h0000);
    nxt();
    #4;
    chk("rst_after", {fifo_count, out_valid, busy}, {5'd0, 1'b0, 1'b0});
    nxt();

`ifdef GLB_PSUM_GATHER_CNT_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 26; k++) begin
        if (k < 24) drive(8'hFF, (k >= 16) ? 8'hFF : 8'h00, 1'b1, 16'hC000);
        else        drive(8'h00, 8'h00, 1'b1, 16'h0000);
        #4;
        if (out_valid && out_last) begin
          chk("fw_pre", frame_words, 16'd23);
          seen = 1'b1;
        end
        nxt();
      end
      #4;
      chk("fw_seen", seen, 1'b1);
      chk("fw_post", frame_words, 16'd0);
      nxt();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
